tri_pixel_buffer: RTL and testbench

Downstream consumer of the triangle rasterizer. Captures every interior point the rasterizer emits on `po/xo/yo` into an 8x8 occupancy bitmap during one triangle frame, bracketed by the rasterizer's `busy`. When the frame ends it drains the bitmap row by row over a valid/ready handshake toward the display/compare stage. Also reports the pixel count and protocol errors.

---
 rtl/tri_pixel_buffer.sv | 96 +++++++++
 tb/tb_tri_pixel_buffer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tri_pixel_buffer.sv
// Occupancy bitmap for one rasterizer frame: collects points while busy is high,
// then drains the 8x8 bitmap row by row over a valid/ready handshake.
module tri_pixel_buffer (
    input  logic       clk,
    input  logic       reset,
    input  logic       busy,
    input  logic       po,
    input  logic [2:0] xo,
    input  logic [2:0] yo,
    input  logic       rd_ready,
    output logic       row_valid,
    output logic [2:0] row_idx,
    output logic [7:0] row_data,
    output logic [6:0] pix_cnt,
    output logic       frame_done,
    output logic       dup_err,
    output logic       proto_err
);

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

    state_t     state, state_nx;
    logic       busy_d;
    logic [7:0] bitmap [8];
    logic       rise, fall, xfer, last_xfer;

    assign rise = busy & ~busy_d;
    assign fall = ~busy & busy_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        row_valid = (state == DRAIN);
        row_data  = row_valid ? bitmap[row_idx] : '0;
        xfer      = row_valid & rd_ready;
        last_xfer = xfer && (row_idx == 3'd7);
        state_nx  = state;
        case (state)
            IDLE:    if (rise)      state_nx = COLLECT;
            COLLECT: if (fall)      state_nx = DRAIN;
            DRAIN:   if (last_xfer) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_d     <= 1'b0;
            row_idx    <= '0;
            pix_cnt    <= '0;
            frame_done <= 1'b0;
            dup_err    <= 1'b0;
            proto_err  <= 1'b0;
            for (int unsigned r = 0; r < 8; r++) bitmap[3'(r)] <= '0;
        end else begin
            busy_d     <= busy;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        // Clear and capture a coincident point in one step.
                        for (int unsigned r = 0; r < 8; r++)
                            bitmap[3'(r)] <= (po && yo == 3'(r)) ? (8'd1 << xo) : '0;
                        pix_cnt <= po ? 7'd1 : 7'd0;
                        dup_err <= 1'b0;
                    end else if (po) begin
                        proto_err <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (po) begin
                        if (bitmap[yo][xo]) begin
                            dup_err <= 1'b1;
                        end else begin
                            bitmap[yo][xo] <= 1'b1;
                            if (pix_cnt != 7'd64) pix_cnt <= pix_cnt + 7'd1;
                        end
                    end
                    if (fall) row_idx <= '0;
                end
                DRAIN: begin
                    if (po || rise) proto_err <= 1'b1;
                    if (xfer) begin
                        row_idx <= row_idx + 3'd1;
                        if (last_xfer) frame_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tri_pixel_buffer.sv
// Directed self-checking bench for tri_pixel_buffer.
module tb_tri_pixel_buffer;

    logic       clk = 1'b0;
    logic       reset, busy, po, rd_ready;
    logic [2:0] xo, yo;
    logic       row_valid, frame_done, dup_err, proto_err;
    logic [2:0] row_idx;
    logic [7:0] row_data;
    logic [6:0] pix_cnt;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_row [8];

    tri_pixel_buffer dut (
        .clk(clk), .reset(reset), .busy(busy), .po(po), .xo(xo), .yo(yo),
        .rd_ready(rd_ready), .row_valid(row_valid), .row_idx(row_idx),
        .row_data(row_data), .pix_cnt(pix_cnt), .frame_done(frame_done),
        .dup_err(dup_err), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_point(input logic [2:0] x, input logic [2:0] y);
        po = 1'b1; xo = x; yo = y;
        tick();
        po = 1'b0;
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 8; i++) exp_row[i] = 8'h00;
    endtask

    task automatic test_reset();
        reset = 1'b1; busy = 1'b0; po = 1'b0; xo = '0; yo = '0; rd_ready = 1'b0;
        tick(); tick();
        checks++;
        if ({row_valid, row_idx, row_data, pix_cnt, frame_done, dup_err, proto_err} !== 22'd0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%0b idx=%0d data=%h cnt=%0d done=%0b dup=%0b proto=%0b, want all 0",
                     row_valid, row_idx, row_data, pix_cnt, frame_done, dup_err, proto_err);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_frame();
        busy = 1'b1; tick();
        send_point(3'd1, 3'd1);
        send_point(3'd2, 3'd1);
        send_point(3'd1, 3'd2);
        send_point(3'd3, 3'd4);
        checks++;
        if (pix_cnt !== 7'd4) begin errors++; $display("FAIL single_pix_cnt: got %0d want 4", pix_cnt); end
        clear_exp();
        exp_row[1] = 8'b0000_0110; exp_row[2] = 8'b0000_0010; exp_row[4] = 8'b0000_1000;
        busy = 1'b0; rd_ready = 1'b1;
        tick();
        for (int r = 0; r < 8; r++) begin
            checks++;
            if (row_valid !== 1'b1) begin errors++; $display("FAIL single_valid row %0d: got %0b want 1", r, row_valid); end
            checks++;
            if (row_idx !== 3'(r)) begin errors++; $display("FAIL single_idx: got %0d want %0d", row_idx, r); end
            checks++;
            if (row_data !== exp_row[r]) begin errors++; $display("FAIL single_data row %0d: got %h want %h", r, row_data, exp_row[r]); end
            checks++;
            if (frame_done !== 1'b0) begin errors++; $display("FAIL single_early_done row %0d: got %0b want 0", r, frame_done); end
            tick();
        end
        checks++;
        if (frame_done !== 1'b1 || row_valid !== 1'b0) begin
            errors++; $display("FAIL single_done: got done=%0b valid=%0b want done=1 valid=0", frame_done, row_valid);
        end
        checks++;
        if (dup_err !== 1'b0 || proto_err !== 1'b0) begin
            errors++; $display("FAIL single_errs: got dup=%0b proto=%0b want 0 0", dup_err, proto_err);
        end
    endtask

    // Starts the next frame in the frame_done cycle left by test_single_frame.
    task automatic test_back_to_back();
        busy = 1'b1; rd_ready = 1'b0;
        send_point(3'd1, 3'd0);
        checks++;
        if (frame_done !== 1'b0 || pix_cnt !== 7'd1) begin
            errors++; $display("FAIL b2b_start: got done=%0b cnt=%0d want done=0 cnt=1", frame_done, pix_cnt);
        end
        busy = 1'b0; rd_ready = 1'b1;
        tick();
        for (int r = 0; r < 8; r++) begin
            checks++;
            if (row_idx !== 3'(r) || row_data !== (r == 0 ? 8'h02 : 8'h00)) begin
                errors++; $display("FAIL b2b_row %0d: got idx=%0d data=%h", r, row_idx, row_data);
            end
            tick();
        end
        checks++;
        if (frame_done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %0b want 1", frame_done); end
        tick();
    endtask

    task automatic test_duplicate();
        busy = 1'b1; tick();
        checks++;
        if (pix_cnt !== 7'd0 || dup_err !== 1'b0) begin
            errors++; $display("FAIL dup_start_clear: got cnt=%0d dup=%0b want 0 0", pix_cnt, dup_err);
        end
        send_point(3'd5, 3'd5);
        checks++;
        if (dup_err !== 1'b0) begin errors++; $display("FAIL dup_first: got %0b want 0", dup_err); end
        send_point(3'd5, 3'd5);
        checks++;
        if (pix_cnt !== 7'd1 || dup_err !== 1'b1) begin
            errors++; $display("FAIL dup_flag: got cnt=%0d dup=%0b want cnt=1 dup=1", pix_cnt, dup_err);
        end
        busy = 1'b0; rd_ready = 1'b1;
        tick();
        for (int r = 0; r < 8; r++) begin
            checks++;
            if (row_data !== (r == 5 ? 8'b0010_0000 : 8'h00)) begin
                errors++; $display("FAIL dup_row %0d: got %h", r, row_data);
            end
            tick();
        end
        checks++;
        if (dup_err !== 1'b1) begin errors++; $display("FAIL dup_sticky: got %0b want 1", dup_err); end
        tick();
    endtask

    task automatic test_backpressure();
        int n;
        int cyc;
        busy = 1'b1; rd_ready = 1'b0; tick();
        send_point(3'd0, 3'd3);
        send_point(3'd7, 3'd6);
        clear_exp();
        exp_row[3] = 8'h01; exp_row[6] = 8'h80;
        busy = 1'b0;
        tick();
        n = 0; cyc = 0;
        while (n < 8 && cyc < 60) begin
            rd_ready = (cyc % 3 == 0);
            checks++;
            if (row_valid !== 1'b1 || row_idx !== 3'(n) || row_data !== exp_row[n]) begin
                errors++; $display("FAIL bp_row: got valid=%0b idx=%0d data=%h want 1 %0d %h",
                                   row_valid, row_idx, row_data, n, exp_row[n]);
            end
            if (rd_ready) n++;
            tick();
            cyc++;
        end
        checks++;
        if (n !== 8 || frame_done !== 1'b1) begin
            errors++; $display("FAIL bp_done: got transfers=%0d done=%0b want 8 1", n, frame_done);
        end
        rd_ready = 1'b0;
        tick();
    endtask

    task automatic test_edge_coincidence();
        busy = 1'b1;
        send_point(3'd0, 3'd0);
        checks++;
        if (pix_cnt !== 7'd1) begin errors++; $display("FAIL edge_rise_cnt: got %0d want 1", pix_cnt); end
        busy = 1'b0; rd_ready = 1'b1;
        send_point(3'd7, 3'd7);
        checks++;
        if (pix_cnt !== 7'd2 || row_valid !== 1'b1) begin
            errors++; $display("FAIL edge_fall: got cnt=%0d valid=%0b want 2 1", pix_cnt, row_valid);
        end
        for (int r = 0; r < 8; r++) begin
            checks++;
            if (row_data !== (r == 0 ? 8'h01 : (r == 7 ? 8'h80 : 8'h00))) begin
                errors++; $display("FAIL edge_row %0d: got %h", r, row_data);
            end
            tick();
        end
        checks++;
        if (proto_err !== 1'b0) begin errors++; $display("FAIL edge_proto: got %0b want 0", proto_err); end
        tick();
    endtask

    task automatic test_protocol();
        int n;
        int cyc;
        send_point(3'd3, 3'd3);
        checks++;
        if (proto_err !== 1'b1 || pix_cnt !== 7'd2) begin
            errors++; $display("FAIL proto_idle: got proto=%0b cnt=%0d want 1 2", proto_err, pix_cnt);
        end
        busy = 1'b1; tick();
        send_point(3'd6, 3'd0);
        busy = 1'b0; rd_ready = 1'b1;
        tick();
        n = 0; cyc = 0;
        while (n < 8 && cyc < 30) begin
            busy = (cyc == 2);
            po = (cyc == 4); xo = 3'd2; yo = 3'd4;
            checks++;
            if (row_valid !== 1'b1 || row_idx !== 3'(n) || row_data !== (n == 0 ? 8'h40 : 8'h00)) begin
                errors++; $display("FAIL proto_drain: got valid=%0b idx=%0d data=%h at row %0d", row_valid, row_idx, row_data, n);
            end
            n++;
            tick();
            cyc++;
        end
        busy = 1'b0; po = 1'b0;
        checks++;
        if (frame_done !== 1'b1 || proto_err !== 1'b1 || pix_cnt !== 7'd1) begin
            errors++; $display("FAIL proto_end: got done=%0b proto=%0b cnt=%0d want 1 1 1", frame_done, proto_err, pix_cnt);
        end
        tick();
    endtask

    task automatic test_reset_mid_drain();
        busy = 1'b1; tick();
        send_point(3'd2, 3'd3);
        busy = 1'b0; rd_ready = 1'b1;
        tick();
        tick(); tick(); tick();
        checks++;
        if (row_idx !== 3'd3 || row_data !== 8'h04) begin
            errors++; $display("FAIL rst_pre: got idx=%0d data=%h want 3 04", row_idx, row_data);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({row_valid, row_idx, row_data, pix_cnt, frame_done, dup_err, proto_err} !== 22'd0) begin
            errors++;
            $display("FAIL rst_async: got valid=%0b idx=%0d data=%h cnt=%0d done=%0b dup=%0b proto=%0b, want all 0",
                     row_valid, row_idx, row_data, pix_cnt, frame_done, dup_err, proto_err);
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (frame_done !== 1'b0 || row_valid !== 1'b0) begin
                errors++; $display("FAIL rst_no_done: got done=%0b valid=%0b want 0 0", frame_done, row_valid);
            end
        end
        busy = 1'b1; tick();
        send_point(3'd4, 3'd6);
        busy = 1'b0;
        tick();
        for (int r = 0; r < 8; r++) begin
            checks++;
            if (row_data !== (r == 6 ? 8'h10 : 8'h00)) begin
                errors++; $display("FAIL rst_new_row %0d: got %h", r, row_data);
            end
            tick();
        end
        checks++;
        if (frame_done !== 1'b1 || pix_cnt !== 7'd1) begin
            errors++; $display("FAIL rst_new_done: got done=%0b cnt=%0d want 1 1", frame_done, pix_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_duplicate();
        test_backpressure();
        test_edge_coincidence();
        test_protocol();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
